// File: rtl/gpu_brush_writer.sv
// Brush stamp writer: paints a square of (cmd_size+1)^2 pixels into the GPU, one write every two cycles at best.
// Optional clipping against the panel edge is enabled by defining BRUSH_CLIP_EN; otherwise coordinates wrap.
module gpu_brush_writer #(
    parameter int GRID_W = 64,
    parameter int GRID_H = 64
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [5:0] cmd_x,
    input  logic [5:0] cmd_y,
    input  logic [2:0] cmd_size,
    input  logic [7:0] cmd_color,
    input  logic       cmd_overlay,
    input  logic       cmd_palette,
    input  logic       write_available,
    output logic       write,
    output logic [7:0] px_data,
    output logic [5:0] column,
    output logic [5:0] row,
    output logic       image_palette,
    output logic       image_overlay,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic [2:0] size_q, size_d;
    logic [7:0] color_q, color_d;
    logic       ovl_q, ovl_d;
    logic       pal_q, pal_d;
    logic [2:0] dx_q, dx_d;
    logic [2:0] dy_q, dy_d;

    logic [6:0] sum_x;
    logic [6:0] sum_y;
    logic       pix_ok;
    logic       last_pix;

    // Sums are kept one bit wider so an off-panel pixel is distinguishable from a wrapped one.
    assign sum_x    = {1'b0, x_q} + {4'b0, dx_q};
    assign sum_y    = {1'b0, y_q} + {4'b0, dy_q};
    assign last_pix = (dx_q == size_q) && (dy_q == size_q);

`ifdef BRUSH_CLIP_EN
    assign pix_ok = (int'(sum_x) < GRID_W) && (int'(sum_y) < GRID_H);
    assign column = sum_x[5:0];
    assign row    = sum_y[5:0];
`else
    assign pix_ok = 1'b1;
    assign column = 6'(sum_x % 7'(GRID_W));
    assign row    = 6'(sum_y % 7'(GRID_H));
`endif

    assign px_data       = color_q;
    assign image_palette = pal_q;
    assign image_overlay = ovl_q;
    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q == ISSUE) || (state_q == GAP);
    assign done          = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        size_d  = size_q;
        color_d = color_q;
        ovl_d   = ovl_q;
        pal_d   = pal_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        write   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    size_d  = cmd_size;
                    color_d = cmd_color;
                    ovl_d   = cmd_overlay;
                    pal_d   = cmd_palette;
                    dx_d    = 3'd0;
                    dy_d    = 3'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A clipped pixel is skipped without waiting for the GPU.
                if (!pix_ok) begin
                    state_d = GAP;
                end else if (write_available) begin
                    write   = 1'b1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (last_pix) begin
                    state_d = DONE;
                end else begin
                    state_d = ISSUE;
                    if (dx_q == size_q) begin
                        dx_d = 3'd0;
                        dy_d = dy_q + 3'd1;
                    end else begin
                        dx_d = dx_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            x_q     <= 6'd0;
            y_q     <= 6'd0;
            size_q  <= 3'd0;
            color_q <= 8'd0;
            ovl_q   <= 1'b0;
            pal_q   <= 1'b0;
            dx_q    <= 3'd0;
            dy_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            size_q  <= size_d;
            color_q <= color_d;
            ovl_q   <= ovl_d;
            pal_q   <= pal_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

endmodule
